// File: rtl/scope_pkg.sv
// Shared constants, FSM encoding and sample-to-entry mapping for the scope capture block.
package scope_pkg;

   localparam int SMP_W     = 6;
   localparam int ENT_W     = 4;
   localparam int DEPTH_DEF = 32;
   localparam int DECIM_DEF = 4;
   localparam int LPE_DEF   = 8;
   localparam int TMO_DEF   = 4;
   localparam logic [SMP_W-1:0] THRESH_DEF = 6'd32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_CAPT = 2'd2,
      ST_DONE = 2'd3
   } cap_state_t;

   // Stored entries keep only the top bits of a sample.
   function automatic logic [ENT_W-1:0] smp_to_entry(input logic [SMP_W-1:0] s);
      return s[SMP_W-1 -: ENT_W];
   endfunction

endpackage

// File: rtl/scope_capture_if.sv
// Sample input, VGA timing pulses and display output of the scope capture block.
interface scope_capture_if;
   import scope_pkg::*;

   logic             ena;
   logic             smp_valid;
   logic [SMP_W-1:0] smp;
   logic             hline;
   logic             frame;
   logic [ENT_W-1:0] s1;
   logic             trig;

   modport master (
      output ena, smp_valid, smp, hline, frame,
      input  s1, trig
   );

   modport slave (
      input  ena, smp_valid, smp, hline, frame,
      output s1, trig
   );

endinterface

// File: rtl/scope_bank.sv
// Two capture banks in one RAM; writes go to the bank not selected for display.
module scope_bank
   import scope_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     bank_sel_i,
   input  logic                     wr_en_i,
   input  logic [$clog2(DEPTH)-1:0] wr_idx_i,
   input  logic [ENT_W-1:0]         wr_data_i,
   input  logic                     rd_en_i,
   input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
   output logic [ENT_W-1:0]         rd_data_o
);

   localparam int AW = $clog2(DEPTH);

   logic [ENT_W-1:0] mem_q [2*DEPTH];
   logic [ENT_W-1:0] rd_data_q;
   logic [AW:0]      wr_addr;
   logic [AW:0]      rd_addr;

   assign wr_addr = {~bank_sel_i, wr_idx_i};
   assign rd_addr = { bank_sel_i, rd_idx_i};

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr] <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/scope_capture.sv
// Triggered, decimated two-bank oscilloscope capture with line-paced display readout.
module scope_capture
   import scope_pkg::*;
#(
   parameter int               DEPTH  = DEPTH_DEF,
   parameter int               DECIM  = DECIM_DEF,
   parameter logic [SMP_W-1:0] THRESH = THRESH_DEF,
   parameter int               LPE    = LPE_DEF,
   parameter int               TMO    = TMO_DEF
) (
   input  logic          clk_i,
   input  logic          rst_i,
   scope_capture_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = $clog2(DECIM + 1);
   localparam int LW = $clog2(LPE + 1);
   localparam int FW = $clog2(TMO + 1);

   localparam logic [AW-1:0] IDX_LAST  = AW'(DEPTH - 1);
   localparam logic [DW-1:0] DEC_LAST  = DW'(DECIM - 1);
   localparam logic [LW-1:0] LINE_LAST = LW'(LPE - 1);
   localparam logic [FW-1:0] FRM_LAST  = FW'(TMO - 1);

   cap_state_t       state_q;
   logic             bank_sel_q;
   logic             bank_sel_d;
   logic             shown_q;
   logic             trig_q;
   logic             auto_q;
   logic [SMP_W-1:0] prev_q;
   logic [DW-1:0]    dec_q;
   logic [AW-1:0]    wr_idx_q;
   logic [FW-1:0]    frm_cnt_q;
   logic [LW-1:0]    line_q;
   logic [AW-1:0]    rd_idx_q;

   logic             frame_e;
   logic             hline_e;
   logic             valid_e;
   logic             trig_hit;
   logic             tmo_hit;
   logic             start_capt;
   logic             capt_smp;
   logic             wr_en;
   logic             swap;
   logic             rd_en;
   logic [AW-1:0]    rd_idx_sel;
   logic [ENT_W-1:0] rd_data;

   assign frame_e = bus.ena & bus.frame;
   assign hline_e = bus.ena & bus.hline;
   assign valid_e = bus.ena & bus.smp_valid;

   assign trig_hit   = (state_q == ST_ARM) && valid_e && (prev_q < THRESH) && (bus.smp >= THRESH);
   assign tmo_hit    = (state_q == ST_ARM) && frame_e && (frm_cnt_q == FRM_LAST);
   assign start_capt = trig_hit | tmo_hit;

   // A sample arriving with the arming event is the first of the first group.
   assign capt_smp = valid_e && ((state_q == ST_CAPT) || start_capt);
   assign wr_en    = capt_smp && (dec_q == DEC_LAST);

   assign swap       = (state_q == ST_DONE) && frame_e;
   assign bank_sel_d = bank_sel_q ^ swap;

   assign rd_en      = frame_e | hline_e;
   assign rd_idx_sel = frame_e ? '0 : rd_idx_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         bank_sel_q <= 1'b0;
         shown_q    <= 1'b0;
         trig_q     <= 1'b0;
         auto_q     <= 1'b0;
         prev_q     <= '0;
         dec_q      <= '0;
         wr_idx_q   <= '0;
         frm_cnt_q  <= '0;
      end else if (bus.ena) begin
         bank_sel_q <= bank_sel_d;
         case (state_q)
            ST_IDLE: begin
               if (frame_e) begin
                  state_q   <= ST_ARM;
                  prev_q    <= '0;
                  frm_cnt_q <= '0;
                  dec_q     <= '0;
                  wr_idx_q  <= '0;
               end
            end
            ST_ARM: begin
               if (frame_e && !tmo_hit) begin
                  frm_cnt_q <= frm_cnt_q + 1'b1;
               end
               if (valid_e) begin
                  prev_q <= bus.smp;
               end
               if (start_capt) begin
                  state_q <= ST_CAPT;
                  auto_q  <= ~trig_hit;
               end
            end
            ST_CAPT: begin
            end
            ST_DONE: begin
               if (frame_e) begin
                  state_q   <= ST_ARM;
                  trig_q    <= ~auto_q;
                  shown_q   <= 1'b1;
                  prev_q    <= '0;
                  frm_cnt_q <= '0;
                  dec_q     <= '0;
                  wr_idx_q  <= '0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
         if (capt_smp) begin
            if (dec_q == DEC_LAST) begin
               dec_q    <= '0;
               wr_idx_q <= wr_idx_q + 1'b1;
               if (wr_idx_q == IDX_LAST) begin
                  state_q <= ST_DONE;
               end
            end else begin
               dec_q <= dec_q + 1'b1;
            end
         end
      end
   end

   // Display pacing: LPE lines per entry, holding on the last entry.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         line_q   <= '0;
         rd_idx_q <= '0;
      end else if (frame_e) begin
         line_q   <= '0;
         rd_idx_q <= '0;
      end else if (hline_e) begin
         if (line_q == LINE_LAST) begin
            line_q <= '0;
            if (rd_idx_q != IDX_LAST) begin
               rd_idx_q <= rd_idx_q + 1'b1;
            end
         end else begin
            line_q <= line_q + 1'b1;
         end
      end
   end

   scope_bank #(
      .DEPTH (DEPTH)
   ) u_bank (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .bank_sel_i (bank_sel_d),
      .wr_en_i    (wr_en),
      .wr_idx_i   (wr_idx_q),
      .wr_data_i  (smp_to_entry(bus.smp)),
      .rd_en_i    (rd_en),
      .rd_idx_i   (rd_idx_sel),
      .rd_data_o  (rd_data)
   );

   assign bus.s1   = shown_q ? rd_data : '0;
   assign bus.trig = trig_q;

endmodule

// File: tb/tb_scope_capture.sv
// Scenario bench for scope_capture: expected display values queued per event, compared one cycle later.
module tb_scope_capture;
   import scope_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   int   exp_q[$];

   scope_capture_if dif();

   scope_capture dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (dif)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog s1=%0d trig=%0d required=finish", dif.s1, dif.trig);
      $fatal(1, "watchdog expired");
   end

   task automatic drive(input logic f, input logic h, input logic v, input logic [5:0] s);
      dif.frame = f;
      dif.hline = h;
      dif.smp_valid = v;
      dif.smp = s;
      @(posedge clk);
      #1;
      dif.frame = 1'b0;
      dif.hline = 1'b0;
      dif.smp_valid = 1'b0;
   endtask

   // Display event with its expected s1 queued for the scoreboard.
   task automatic ev(input logic f, input logic h, input logic v, input logic [5:0] s, input int e);
      exp_q.push_back(e);
      drive(f, h, v, s);
   endtask

   task automatic feed_ramp(input int lo, input int hi);
      for (int k = lo; k <= hi; k++) drive(1'b0, 1'b0, 1'b1, 6'(k));
   endtask

   task automatic feed_const(input int n, input logic [5:0] v);
      for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b1, v);
   endtask

   // Ramp 0..63 wrapping, trigger on value 32, last of each group of 4 kept, top 4 bits.
   function automatic int ramp_entry(input int e);
      return ((32 + 4 * e + 3) & 63) >> 2;
   endfunction

   task automatic test_reset();
      int e;
      rst = 1'b1;
      dif.ena = 1'b1;
      dif.frame = 1'b0;
      dif.hline = 1'b0;
      dif.smp_valid = 1'b0;
      dif.smp = '0;
      repeat (3) begin @(posedge clk); #1; end
      checks++;
      if (dif.s1 !== 4'd0) begin errors++; $display("FAIL reset_s1 got=%0d required=0", dif.s1); end
      checks++;
      if (dif.trig !== 1'b0) begin errors++; $display("FAIL reset_trig got=%0d required=0", dif.trig); end
      rst = 1'b0;
      ev(1'b0, 1'b1, 1'b0, 6'd0, 0);
      e = exp_q.pop_front();
      checks++;
      if (dif.s1 !== 4'(e)) begin errors++; $display("FAIL reset_hline got=%0d required=%0d", dif.s1, e); end
      $display("reset: s1=%0d trig=%0d", dif.s1, dif.trig);
   endtask

   task automatic test_ramp_trigger();
      int e;
      ev(1'b1, 1'b0, 1'b0, 6'd0, 0);
      e = exp_q.pop_front();
      checks++;
      if (dif.s1 !== 4'(e)) begin errors++; $display("FAIL ramp_arm got=%0d required=%0d", dif.s1, e); end
      feed_ramp(0, 159);
      ev(1'b0, 1'b1, 1'b0, 6'd0, 0);
      e = exp_q.pop_front();
      checks++;
      if (dif.s1 !== 4'(e)) begin errors++; $display("FAIL ramp_preswap got=%0d required=%0d", dif.s1, e); end
      ev(1'b1, 1'b0, 1'b0, 6'd0, ramp_entry(0));
      e = exp_q.pop_front();
      checks++;
      if (dif.s1 !== 4'(e)) begin errors++; $display("FAIL ramp_swap got=%0d required=%0d", dif.s1, e); end
      checks++;
      if (dif.trig !== 1'b1) begin errors++; $display("FAIL ramp_trig got=%0d required=1", dif.trig); end
      for (int p = 1; p <= 300; p++) begin
         int idx;
         idx = (p - 1) / 8;
         if (idx > 31) idx = 31;
         ev(1'b0, 1'b1, 1'b0, 6'd0, ramp_entry(idx));
         e = exp_q.pop_front();
         checks++;
         if (dif.s1 !== 4'(e)) begin
            errors++;
            $display("FAIL ramp_hline pulse=%0d got=%0d required=%0d", p, dif.s1, e);
         end else if (p <= 17 || p == 300) begin
            $display("hline %0d: s1=%0d", p, dif.s1);
         end
      end
   endtask

   task automatic test_ena_low();
      int e;
      ev(1'b1, 1'b0, 1'b0, 6'd0, ramp_entry(0));
      e = exp_q.pop_front();
      checks++;
      if (dif.s1 !== 4'(e)) begin errors++; $display("FAIL ena_frame got=%0d required=%0d", dif.s1, e); end
      for (int p = 1; p <= 10; p++) ev(1'b0, 1'b1, 1'b0, 6'd0, ramp_entry((p - 1) / 8));
      repeat (9) void'(exp_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (dif.s1 !== 4'(e)) begin errors++; $display("FAIL ena_pre got=%0d required=%0d", dif.s1, e); end
      dif.ena = 1'b0;
      for (int c = 0; c < 100; c++) begin
         dif.frame = 1'($urandom_range(0, 1));
         dif.hline = 1'($urandom_range(0, 1));
         dif.smp_valid = 1'($urandom_range(0, 1));
         dif.smp = 6'($urandom_range(0, 63));
         @(posedge clk);
         #1;
         checks++;
         if (dif.s1 !== 4'(ramp_entry(1)) || dif.trig !== 1'b1) begin
            errors++;
            $display("FAIL ena_hold cycle=%0d s1=%0d trig=%0d required s1=%0d trig=1", c, dif.s1, dif.trig, ramp_entry(1));
         end
      end
      dif.frame = 1'b0;
      dif.hline = 1'b0;
      dif.smp_valid = 1'b0;
      dif.ena = 1'b1;
      for (int p = 11; p <= 17; p++) begin
         ev(1'b0, 1'b1, 1'b0, 6'd0, ramp_entry((p - 1) / 8));
         e = exp_q.pop_front();
         checks++;
         if (dif.s1 !== 4'(e)) begin errors++; $display("FAIL ena_resume pulse=%0d got=%0d required=%0d", p, dif.s1, e); end
      end
      $display("ena low: held s1=%0d", ramp_entry(1));
   endtask

   task automatic test_frame_during_capt();
      int e;
      feed_ramp(0, 31);
      feed_const(20, 6'd60);
      ev(1'b1, 1'b0, 1'b1, 6'd60, ramp_entry(0));
      e = exp_q.pop_front();
      checks++;
      if (dif.s1 !== 4'(e)) begin errors++; $display("FAIL capt_frame got=%0d required=%0d", dif.s1, e); end
      checks++;
      if (dif.trig !== 1'b1) begin errors++; $display("FAIL capt_frame_trig got=%0d required=1", dif.trig); end
      feed_const(120, 6'd60);
      ev(1'b1, 1'b0, 1'b0, 6'd0, 15);
      e = exp_q.pop_front();
      checks++;
      if (dif.s1 !== 4'(e)) begin errors++; $display("FAIL capt_swap got=%0d required=%0d", dif.s1, e); end
      for (int p = 1; p <= 3; p++) begin
         ev(1'b0, 1'b1, 1'b0, 6'd0, 15);
         e = exp_q.pop_front();
         checks++;
         if (dif.s1 !== 4'(e)) begin errors++; $display("FAIL capt_hline pulse=%0d got=%0d required=%0d", p, dif.s1, e); end
      end
      $display("frame in capture: swap deferred, s1=%0d", dif.s1);
   endtask

   task automatic test_auto_trigger();
      int e;
      for (int f = 1; f <= 4; f++) begin
         feed_const(140, 6'd10);
         ev(1'b1, 1'b0, 1'b1, 6'd10, 15);
         e = exp_q.pop_front();
         checks++;
         if (dif.s1 !== 4'(e) || dif.trig !== 1'b1) begin
            errors++;
            $display("FAIL auto_frame%0d s1=%0d trig=%0d required s1=%0d trig=1", f, dif.s1, dif.trig, e);
         end
      end
      feed_const(140, 6'd10);
      ev(1'b1, 1'b0, 1'b0, 6'd0, 2);
      e = exp_q.pop_front();
      checks++;
      if (dif.s1 !== 4'(e)) begin errors++; $display("FAIL auto_swap got=%0d required=%0d", dif.s1, e); end
      checks++;
      if (dif.trig !== 1'b0) begin errors++; $display("FAIL auto_trig got=%0d required=0", dif.trig); end
      for (int p = 1; p <= 10; p++) begin
         ev(1'b0, 1'b1, 1'b0, 6'd0, 2);
         e = exp_q.pop_front();
         checks++;
         if (dif.s1 !== 4'(e)) begin errors++; $display("FAIL auto_hline pulse=%0d got=%0d required=%0d", p, dif.s1, e); end
      end
      $display("auto trigger: s1=%0d trig=%0d", dif.s1, dif.trig);
   endtask

   task automatic test_reset_mid_capt();
      int e;
      feed_ramp(0, 31);
      feed_const(30, 6'd60);
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 6'd0);
      rst = 1'b0;
      checks++;
      if (dif.s1 !== 4'd0 || dif.trig !== 1'b0) begin
         errors++;
         $display("FAIL midrst s1=%0d trig=%0d required s1=0 trig=0", dif.s1, dif.trig);
      end
      ev(1'b0, 1'b1, 1'b0, 6'd0, 0);
      e = exp_q.pop_front();
      checks++;
      if (dif.s1 !== 4'(e)) begin errors++; $display("FAIL midrst_hline got=%0d required=%0d", dif.s1, e); end
      ev(1'b1, 1'b0, 1'b0, 6'd0, 0);
      e = exp_q.pop_front();
      checks++;
      if (dif.s1 !== 4'(e)) begin errors++; $display("FAIL midrst_arm got=%0d required=%0d", dif.s1, e); end
      feed_ramp(0, 31);
      feed_const(50, 6'd60);
      ev(1'b1, 1'b0, 1'b1, 6'd60, 0);
      e = exp_q.pop_front();
      checks++;
      if (dif.s1 !== 4'(e)) begin errors++; $display("FAIL midrst_capt_frame got=%0d required=%0d", dif.s1, e); end
      feed_const(100, 6'd60);
      ev(1'b0, 1'b1, 1'b0, 6'd0, 0);
      e = exp_q.pop_front();
      checks++;
      if (dif.s1 !== 4'(e)) begin errors++; $display("FAIL midrst_done got=%0d required=%0d", dif.s1, e); end
      ev(1'b1, 1'b0, 1'b0, 6'd0, 15);
      e = exp_q.pop_front();
      checks++;
      if (dif.s1 !== 4'(e)) begin errors++; $display("FAIL midrst_swap got=%0d required=%0d", dif.s1, e); end
      checks++;
      if (dif.trig !== 1'b1) begin errors++; $display("FAIL midrst_trig got=%0d required=1", dif.trig); end
      $display("reset mid capture: recovered s1=%0d trig=%0d", dif.s1, dif.trig);
   endtask

   initial begin
      test_reset();
      test_ramp_trigger();
      test_ena_low();
      test_frame_during_capt();
      test_auto_trigger();
      test_reset_mid_capt();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
